// File: rtl/cache_tag_array_nway_pkg.sv
// Shared types and tree-pLRU helpers for the N-way cache tag array.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// The pLRU helpers work on a vector sized for the widest supported tree (8 ways).
// Callers pass the real tree depth in 'levels' and zero-extend narrower state.
// Tree nodes are heap-ordered: node i has children 2i+1 (left) and 2i+2 (right).
package cache_tag_array_nway_pkg;

    localparam int MAX_WAYS  = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    typedef logic [MAX_WAYS-2:0]  plru_t;
    typedef logic [MAX_IDX_W-1:0] way_idx_t;

    // Width of a way index; never below 1 so ports stay legal.
    function automatic int way_idx_w(input int ways);
        return (ways < 2) ? 1 : $clog2(ways);
    endfunction

    // Walk from the root, 0 = go left, 1 = go right; the path is the victim way.
    function automatic way_idx_t plru_victim(input plru_t bits, input int levels);
        way_idx_t   v;
        logic [3:0] node;
        logic       b;
        v    = '0;
        node = '0;
        for (int l = 0; l < MAX_IDX_W; l++) begin
            if (l < levels) begin
                b    = bits[node[2:0]];
                v    = {v[MAX_IDX_W-2:0], b};
                node = {node[2:0], 1'b0} + 4'd1 + {3'b000, b};
            end
        end
        return v;
    endfunction

    // Mark 'way' most recent: every node on its path points to the other subtree.
    function automatic plru_t plru_touch(input plru_t bits, input way_idx_t way, input int levels);
        plru_t      r;
        way_idx_t   w;
        logic [3:0] node;
        logic       d;
        r    = bits;
        node = '0;
        // Left-align the way index so its MSB selects the root branch.
        w    = way << (MAX_IDX_W - levels);
        for (int l = 0; l < MAX_IDX_W; l++) begin
            if (l < levels) begin
                d            = w[MAX_IDX_W-1];
                r[node[2:0]] = ~d;
                node         = {node[2:0], 1'b0} + 4'd1 + {3'b000, d};
                w            = w << 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_tag_array_nway_tag_way_ram.sv
// One way of tag storage: simple dual-port RAM, {valid, tag} per set.
// Latency: 1 cycle registered read; read-before-write on address collision.
// Backpressure: none; read data register holds while rd_en_i is low.
//
// Ports: clk_i; rd_en_i/rd_addr_i -> rd_data_o (next cycle); wr_en_i/wr_addr_i/wr_data_i.
module tag_way_ram #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 22
) (
    input  logic              clk_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/cache_tag_array_nway.sv
// N-way set-associative tag store with per-set tree pLRU and self-clearing sweep.
// Latency: reads 1 cycle; writes/pLRU touches land at the next edge; sweep 2**SET_W cycles.
// Backpressure: none; while init_busy_o is high all requests are dropped, read outputs are 0.
//
// Ports: clk_i, rst_i (sync, active high), inv_all_i, init_busy_o;
//   read  rd_en_i/rd_set_i -> rd_tag_o (way w at [w*TAG_W +: TAG_W]), rd_valid_o, rd_victim_o;
//   write wr_en_i/wr_set_i/wr_way_i (one-hot)/wr_tag_i/wr_valid_i; pLRU lru_en_i/lru_set_i/lru_way_i.
module cache_tag_array_nway
    import cache_tag_array_nway_pkg::*;
#(
    parameter int SET_W  = 7,
    parameter int TAG_W  = 21,
    parameter int WAYS   = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     inv_all_i,
    output logic                     init_busy_o,
    input  logic                     rd_en_i,
    input  logic [SET_W-1:0]         rd_set_i,
    output logic [WAYS*TAG_W-1:0]    rd_tag_o,
    output logic [WAYS-1:0]          rd_valid_o,
    output logic [$clog2(WAYS)-1:0]  rd_victim_o,
    input  logic                     wr_en_i,
    input  logic [SET_W-1:0]         wr_set_i,
    input  logic [WAYS-1:0]          wr_way_i,
    input  logic [TAG_W-1:0]         wr_tag_i,
    input  logic                     wr_valid_i,
    input  logic                     lru_en_i,
    input  logic [SET_W-1:0]         lru_set_i,
    input  logic [$clog2(WAYS)-1:0]  lru_way_i
);

    localparam int SETS      = 2**SET_W;
    localparam int WAY_IDX_W = way_idx_w(WAYS);
    localparam int LEVELS    = $clog2(WAYS);
    localparam int PLRU_W    = WAYS - 1;

    // ---------------- sweep FSM ----------------
    state_e           state_q;
    logic [SET_W-1:0] ctr_q;
    logic             busy_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            ctr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ctr_q <= ctr_q + 1'b1;
                    if (ctr_q == '1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (inv_all_i) begin
                        state_q <= ST_INIT;
                        ctr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    ctr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign init_busy_o = busy_q;

    logic idle;
    logic rd_fire;
    assign idle    = (state_q == ST_IDLE) && !rst_i;
    assign rd_fire = idle && rd_en_i;

    // ---------------- tag/valid RAMs ----------------
    // The sweep owns the write port while clearing; otherwise the refill path does.
    logic [SET_W-1:0] ram_wr_addr;
    logic [TAG_W:0]   ram_wr_data;
    logic [WAYS-1:0]  ram_wr_en;

    always_comb begin
        ram_wr_addr = wr_set_i;
        ram_wr_data = {wr_valid_i, wr_tag_i};
        ram_wr_en   = '0;
        if (state_q == ST_INIT) begin
            ram_wr_addr = ctr_q;
            ram_wr_data = '0;
            ram_wr_en   = '1;
        end else if (idle && wr_en_i) begin
            ram_wr_en = wr_way_i;
        end
    end

    logic [TAG_W:0] ram_rd_data [WAYS];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        tag_way_ram #(
            .ADDR_W (SET_W),
            .DATA_W (TAG_W + 1)
        ) u_ram (
            .clk_i     (clk_i),
            .rd_en_i   (rd_fire),
            .rd_addr_i (rd_set_i),
            .rd_data_o (ram_rd_data[w]),
            .wr_en_i   (ram_wr_en[w]),
            .wr_addr_i (ram_wr_addr),
            .wr_data_i (ram_wr_data)
        );
    end

    // ---------------- pLRU state ----------------
    logic [PLRU_W-1:0] plru_q [SETS];
    plru_t             plru_touched;
    plru_t             plru_rd_ext;

    always_comb begin
        plru_touched = plru_touch(plru_t'(plru_q[lru_set_i]), way_idx_t'(lru_way_i), LEVELS);
        plru_rd_ext  = plru_t'(plru_q[rd_set_i]);
        // Same-cycle touch of the read set is forwarded so the victim is current.
        if (BYPASS != 0 && lru_en_i && lru_set_i == rd_set_i) begin
            plru_rd_ext = plru_touched;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            plru_q[ctr_q] <= '0;
        end else if (idle && lru_en_i) begin
            plru_q[lru_set_i] <= PLRU_W'(plru_touched);
        end
    end

    // ---------------- read path ----------------
    // The RAMs keep their own read register; alongside it we register which ways
    // take the forwarded write data and whether the outputs must read as zero.
    logic                 clr_q;
    logic [WAYS-1:0]      byp_q;
    logic [TAG_W:0]       byp_dat_q;
    logic [WAY_IDX_W-1:0] victim_q;
    logic [WAYS-1:0]      byp_d;

    assign byp_d = (BYPASS != 0 && wr_en_i && wr_set_i == rd_set_i) ? wr_way_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i || state_q == ST_INIT) begin
            clr_q     <= 1'b1;
            byp_q     <= '0;
            byp_dat_q <= '0;
            victim_q  <= '0;
        end else if (rd_fire) begin
            clr_q     <= 1'b0;
            byp_q     <= byp_d;
            byp_dat_q <= {wr_valid_i, wr_tag_i};
            victim_q  <= WAY_IDX_W'(plru_victim(plru_rd_ext, LEVELS));
        end
    end

    // busy_q covers the first sweep cycle, before clr_q has been loaded.
    always_comb begin
        rd_tag_o   = '0;
        rd_valid_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!(clr_q || busy_q)) begin
                if (byp_q[w]) begin
                    {rd_valid_o[w], rd_tag_o[w*TAG_W +: TAG_W]} = byp_dat_q;
                end else begin
                    {rd_valid_o[w], rd_tag_o[w*TAG_W +: TAG_W]} = ram_rd_data[w];
                end
            end
        end
    end

    assign rd_victim_o = (clr_q || busy_q) ? '0 : victim_q;

endmodule

// File: tb/tb_cache_tag_array_nway.sv
module tb_cache_tag_array_nway;

    localparam int SET_W = 7;
    localparam int TAG_W = 21;
    localparam int WAYS  = 4;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_i, inv_all_i, rd_en_i, wr_en_i, wr_valid_i, lru_en_i;
    logic [6:0]  rd_set_i, wr_set_i, lru_set_i;
    logic [3:0]  wr_way_i;
    logic [20:0] wr_tag_i;
    logic [1:0]  lru_way_i;

    logic        busy_b, busy_n;
    logic [83:0] tag_b, tag_n;
    logic [3:0]  val_b, val_n;
    logic [1:0]  vic_b, vic_n;

    cache_tag_array_nway #(.SET_W(SET_W), .TAG_W(TAG_W), .WAYS(WAYS), .BYPASS(1)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .inv_all_i(inv_all_i), .init_busy_o(busy_b),
        .rd_en_i(rd_en_i), .rd_set_i(rd_set_i), .rd_tag_o(tag_b), .rd_valid_o(val_b),
        .rd_victim_o(vic_b), .wr_en_i(wr_en_i), .wr_set_i(wr_set_i), .wr_way_i(wr_way_i),
        .wr_tag_i(wr_tag_i), .wr_valid_i(wr_valid_i), .lru_en_i(lru_en_i),
        .lru_set_i(lru_set_i), .lru_way_i(lru_way_i)
    );

    cache_tag_array_nway #(.SET_W(SET_W), .TAG_W(TAG_W), .WAYS(WAYS), .BYPASS(0)) dut_n (
        .clk_i(clk_i), .rst_i(rst_i), .inv_all_i(inv_all_i), .init_busy_o(busy_n),
        .rd_en_i(rd_en_i), .rd_set_i(rd_set_i), .rd_tag_o(tag_n), .rd_valid_o(val_n),
        .rd_victim_o(vic_n), .wr_en_i(wr_en_i), .wr_set_i(wr_set_i), .wr_way_i(wr_way_i),
        .wr_tag_i(wr_tag_i), .wr_valid_i(wr_valid_i), .lru_en_i(lru_en_i),
        .lru_set_i(lru_set_i), .lru_way_i(lru_way_i)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [83:0] tb;
        logic [3:0]  vb;
        logic [1:0]  cb;
        logic [83:0] tn;
        logic [3:0]  vn;
        logic [1:0]  cn;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [83:0] t4(input logic [20:0] a3, input logic [20:0] a2,
                                       input logic [20:0] a1, input logic [20:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic issued = 1'b0;
    always @(posedge clk_i) issued <= rd_en_i;

    always @(negedge clk_i) begin
        if (issued) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: read result with no queued expectation");
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, ".tag_byp"},    tag_b, mon_e.tb);
                chk({mon_e.name, ".valid_byp"},  val_b, mon_e.vb);
                chk({mon_e.name, ".victim_byp"}, vic_b, mon_e.cb);
                chk({mon_e.name, ".tag_nob"},    tag_n, mon_e.tn);
                chk({mon_e.name, ".valid_nob"},  val_n, mon_e.vn);
                chk({mon_e.name, ".victim_nob"}, vic_n, mon_e.cn);
            end
        end
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic clear_in();
        rd_en_i   = 1'b0;
        wr_en_i   = 1'b0;
        lru_en_i  = 1'b0;
        inv_all_i = 1'b0;
    endtask

    task automatic step();
        @(negedge clk_i);
        clear_in();
    endtask

    task automatic set_wr(input int s, input logic [3:0] way, input logic [20:0] tag, input logic v);
        wr_en_i    = 1'b1;
        wr_set_i   = 7'(s);
        wr_way_i   = way;
        wr_tag_i   = tag;
        wr_valid_i = v;
    endtask

    task automatic set_lru(input int s, input int w);
        lru_en_i  = 1'b1;
        lru_set_i = 7'(s);
        lru_way_i = 2'(w);
    endtask

    task automatic set_rd2(input string nm, input int s,
                           input logic [83:0] tb, input logic [3:0] vb, input logic [1:0] cb,
                           input logic [83:0] tn, input logic [3:0] vn, input logic [1:0] cn);
        exp_t e;
        rd_en_i  = 1'b1;
        rd_set_i = 7'(s);
        e.name = nm; e.tb = tb; e.vb = vb; e.cb = cb; e.tn = tn; e.vn = vn; e.cn = cn;
        exp_q.push_back(e);
    endtask

    task automatic set_rd(input string nm, input int s,
                          input logic [83:0] t, input logic [3:0] v, input logic [1:0] c);
        set_rd2(nm, s, t, v, c, t, v, c);
    endtask

    // Counts negedges with init_busy high, starting at the current one.
    task automatic count_busy(input string nm, input int wr_at, input int inv_at);
        int n = 0;
        while (busy_b === 1'b1 && n < 400) begin
            n++;
            clear_in();
            if (n == wr_at) set_wr(5, 4'b0001, 21'h777, 1'b1);
            if (n == inv_at) inv_all_i = 1'b1;
            @(negedge clk_i);
        end
        clear_in();
        chk({nm, ".busy_cycles"}, n, 128);
        chk({nm, ".busy_nob_done"}, busy_n, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_i = 1'b1;
        clear_in();
        rd_set_i = '0; wr_set_i = '0; wr_way_i = '0; wr_tag_i = '0; wr_valid_i = 1'b0;
        lru_set_i = '0; lru_way_i = '0;
        @(negedge clk_i);

        // 1: reset state and sweep length
        chk("reset.busy", busy_b, 1);
        chk("reset.tag", tag_b, 0);
        chk("reset.valid", val_b, 0);
        chk("reset.victim", vic_b, 0);
        rst_i = 1'b0;
        count_busy("sweep_after_reset", 0, 0);
        set_rd("clr_set0", 0, 0, 4'b0000, 0);     step();
        set_rd("clr_set5", 5, 0, 4'b0000, 0);     step();
        set_rd("clr_set127", 127, 0, 4'b0000, 0); step();

        // 2: single-way refill
        set_wr(5, 4'b0010, 21'h1ABCD, 1'b1); step();
        set_rd("wr_set5", 5, t4(0, 0, 21'h1ABCD, 0), 4'b0010, 0); step();

        // 3: write/read collision
        set_wr(9, 4'b0001, 21'h11, 1'b1); step();
        set_wr(9, 4'b0001, 21'h55, 1'b1);
        set_rd2("byp_set9", 9, t4(0, 0, 0, 21'h55), 4'b0001, 0,
                               t4(0, 0, 0, 21'h11), 4'b0001, 0); step();
        set_rd("after_byp_set9", 9, t4(0, 0, 0, 21'h55), 4'b0001, 0); step();
        set_wr(10, 4'b0001, 21'h66, 1'b1);
        set_rd("other_set_no_fwd", 9, t4(0, 0, 0, 21'h55), 4'b0001, 0); step();
        set_wr(5, 4'b0001, 21'h22, 1'b1);
        set_rd2("byp_partial_set5", 5, t4(0, 0, 21'h1ABCD, 21'h22), 4'b0011, 0,
                                       t4(0, 0, 21'h1ABCD, 0), 4'b0010, 0); step();

        // multi-way write, single-way invalidate, empty way mask
        set_wr(20, 4'b1100, 21'h3, 1'b1); step();
        set_rd("multi_way_set20", 20, t4(3, 3, 0, 0), 4'b1100, 0); step();
        set_wr(20, 4'b0100, 21'h3, 1'b0); step();
        set_rd("inval_way2_set20", 20, t4(3, 3, 0, 0), 4'b1000, 0); step();
        set_wr(20, 4'b0000, 21'h9, 1'b1); step();
        set_rd("noop_wr_set20", 20, t4(3, 3, 0, 0), 4'b1000, 0); step();

        // top set, max tag, and output hold while rd_en is low
        set_wr(127, 4'b1000, 21'h1FFFFF, 1'b1); step();
        set_rd("max_tag_set127", 127, t4(21'h1FFFFF, 0, 0, 0), 4'b1000, 0); step();
        set_wr(127, 4'b1000, 21'h0, 1'b0); step();
        chk("hold.tag", tag_b, t4(21'h1FFFFF, 0, 0, 0));
        chk("hold.valid", val_b, 4'b1000);
        set_rd("after_hold_set127", 127, 0, 4'b0000, 0); step();

        // 4: pLRU
        set_lru(3, 0); step();
        set_lru(3, 1); step();
        set_lru(3, 2); step();
        set_lru(3, 3); step();
        set_rd("plru_all_touched", 3, 0, 4'b0000, 0); step();
        set_lru(3, 0); step();
        set_rd("plru_touch0", 3, 0, 4'b0000, 2); step();
        set_lru(3, 2);
        set_rd2("plru_byp", 3, 0, 4'b0000, 1, 0, 4'b0000, 2); step();
        set_rd("plru_after_byp", 3, 0, 4'b0000, 1); step();
        set_wr(40, 4'b1000, 21'h40, 1'b1);
        set_lru(40, 0); step();
        set_rd("wr_and_lru_set40", 40, t4(21'h40, 0, 0, 0), 4'b1000, 2); step();

        // 5: invalidate-all; write and inv_all during the sweep are dropped
        inv_all_i = 1'b1; step();
        count_busy("inv_sweep", 10, 30);
        set_rd("inv_set5", 5, 0, 4'b0000, 0);     step();
        set_rd("inv_set9", 9, 0, 4'b0000, 0);     step();
        set_rd("inv_set40", 40, 0, 4'b0000, 0);   step();
        set_rd("inv_set3", 3, 0, 4'b0000, 0);     step();

        // 6: reset in the middle of a sweep restarts it
        inv_all_i = 1'b1; step();
        repeat (60) @(negedge clk_i);
        chk("mid_sweep.busy", busy_b, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        count_busy("rst_mid_sweep", 0, 0);
        set_wr(2, 4'b0010, 21'hABC, 1'b1); step();
        set_rd("post_rst_set2", 2, t4(0, 0, 21'hABC, 0), 4'b0010, 0); step();
        set_rd("post_rst_set20", 20, 0, 4'b0000, 0); step();

        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
